// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: writeback select codes, load funct3
// encodings and the MEM/WB load-wait state encoding.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load data formatter for the MEM/WB stage.
// With LOAD_EXT_EN defined, the returned word is narrowed to the byte or
// halfword lane addressed by addr and sign/zero extended per funct3.
// Without it, the memory word passes through untouched.
module load_extend
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext_data
);

`ifdef LOAD_EXT_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes out of the memory word
    always_comb begin
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign or zero extend the selected lane according to the load type
    always_comb begin
        case (funct3)
            F3_LB:   ext_data = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            F3_LBU:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            F3_LH:   ext_data = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            F3_LHU:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_s};
            F3_LW:   ext_data = rdata;
            default: ext_data = rdata;
        endcase
    end
`else
    // Lane and type information is irrelevant for whole-word loads
    logic unused_s;
    assign unused_s = ^{addr, funct3};
    assign ext_data = rdata;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the pipelined RV32I core.
// Captures MEM results, waits for variable-latency load data (IDLE/WAIT/HOLD),
// requests an upstream stall while a load is outstanding and aborts a load
// that is not answered within MAX_WAIT cycles (load_err pulse).
// Optional feature macro: LOAD_EXT_EN (byte/halfword load extension).
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            funct3M,
    input  logic                  RegWriteM,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [DATA_WIDTH-1:0] ImmExtM,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [DATA_WIDTH-1:0] ImmExtW,
    output logic [1:0]            ResultSrcW,
    output logic                  RegWriteW,
    output logic [ADDR_WIDTH-1:0] RdW,
    output logic                  validW,
    output logic                  stall_req,
    output logic                  load_err
);

    // Last wait-counter value before a load is given up
    localparam logic [7:0] WAIT_LAST_C = 8'(MAX_WAIT - 1);

    wb_state_t             state_r, state_nx_s;
    logic [7:0]            wait_cnt_r, wait_cnt_nx_s;
    logic [1:0]            pend_src_r;
    logic [2:0]            pend_f3_r;
    logic                  pend_rw_r;
    logic [ADDR_WIDTH-1:0] pend_rd_r;
    logic [DATA_WIDTH-1:0] pend_alu_r, pend_pc4_r, pend_imm_r, hold_data_r;

    logic                  is_miss_s, capture_s, bubble_s, latch_s, buffer_s, err_nx_s;
    logic [1:0]            sel_src_s;
    logic [2:0]            sel_f3_s;
    logic                  sel_rw_s;
    logic [ADDR_WIDTH-1:0] sel_rd_s;
    logic [DATA_WIDTH-1:0] sel_alu_s, sel_pc4_s, sel_imm_s, ext_data_s, wr_data_s;

    // In IDLE the live MEM inputs feed writeback; otherwise the latched load does
    always_comb begin
        if (state_r == IDLE) begin
            sel_src_s = ResultSrcM;
            sel_f3_s  = funct3M;
            sel_rw_s  = RegWriteM;
            sel_rd_s  = RdM;
            sel_alu_s = ALUResultM;
            sel_pc4_s = PCPlus4M;
            sel_imm_s = ImmExtM;
        end else begin
            sel_src_s = pend_src_r;
            sel_f3_s  = pend_f3_r;
            sel_rw_s  = pend_rw_r;
            sel_rd_s  = pend_rd_r;
            sel_alu_s = pend_alu_r;
            sel_pc4_s = pend_pc4_r;
            sel_imm_s = pend_imm_r;
        end
    end

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata    (mem_rdata),
        .addr     (sel_alu_s[1:0]),
        .funct3   (sel_f3_s),
        .ext_data (ext_data_s)
    );

    // Load whose data has not arrived in the cycle it reaches MEM
    assign is_miss_s = valid_m && (ResultSrcM == RES_MEM) && !mem_rvalid;

    // Next-state logic for the load-wait machine and writeback actions
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        capture_s     = 1'b0;
        bubble_s      = 1'b0;
        latch_s       = 1'b0;
        buffer_s      = 1'b0;
        err_nx_s      = 1'b0;
        stall_req     = 1'b0;
        if (state_r == HOLD) begin
            wr_data_s = hold_data_r;
        end else begin
            wr_data_s = ext_data_s;
        end
        case (state_r)
            IDLE: begin
                stall_req = is_miss_s;
                if (stall_i) begin
                    state_nx_s = IDLE;
                end else if (!valid_m) begin
                    bubble_s = 1'b1;
                end else if (is_miss_s) begin
                    bubble_s      = 1'b1;
                    latch_s       = 1'b1;
                    wait_cnt_nx_s = 8'd0;
                    state_nx_s    = WAIT;
                end else begin
                    capture_s = 1'b1;
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                if (mem_rvalid) begin
                    wait_cnt_nx_s = 8'd0;
                    if (stall_i) begin
                        buffer_s   = 1'b1;
                        state_nx_s = HOLD;
                    end else begin
                        capture_s  = 1'b1;
                        state_nx_s = IDLE;
                    end
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    bubble_s      = 1'b1;
                    err_nx_s      = 1'b1;
                    wait_cnt_nx_s = 8'd0;
                    state_nx_s    = IDLE;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + 8'd1;
                end
            end
            HOLD: begin
                stall_req = 1'b1;
                if (!stall_i) begin
                    capture_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                wait_cnt_nx_s = 8'd0;
                state_nx_s    = IDLE;
            end
        endcase
        // A flush kills whatever the slot holds, including a pending load
        if (flush_i) begin
            capture_s     = 1'b0;
            bubble_s      = 1'b1;
            latch_s       = 1'b0;
            buffer_s      = 1'b0;
            err_nx_s      = 1'b0;
            wait_cnt_nx_s = 8'd0;
            state_nx_s    = IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State, wait counter, pending load metadata and hold buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 8'd0;
            load_err    <= 1'b0;
            pend_src_r  <= 2'b00;
            pend_f3_r   <= 3'b000;
            pend_rw_r   <= 1'b0;
            pend_rd_r   <= '0;
            pend_alu_r  <= '0;
            pend_pc4_r  <= '0;
            pend_imm_r  <= '0;
            hold_data_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            load_err   <= err_nx_s;
            if (latch_s) begin
                pend_src_r <= ResultSrcM;
                pend_f3_r  <= funct3M;
                pend_rw_r  <= RegWriteM;
                pend_rd_r  <= RdM;
                pend_alu_r <= ALUResultM;
                pend_pc4_r <= PCPlus4M;
                pend_imm_r <= ImmExtM;
            end
            if (buffer_s) begin
                hold_data_r <= ext_data_s;
            end
        end
    end

    // Writeback registers: capture a result, insert a bubble, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            ImmExtW    <= '0;
            ResultSrcW <= 2'b00;
            RegWriteW  <= 1'b0;
            RdW        <= '0;
            validW     <= 1'b0;
        end else if (capture_s) begin
            ALUResultW <= sel_alu_s;
            ReadDataW  <= wr_data_s;
            PCPlus4W   <= sel_pc4_s;
            ImmExtW    <= sel_imm_s;
            ResultSrcW <= sel_src_s;
            RegWriteW  <= sel_rw_s && (sel_rd_s != '0);
            RdW        <= sel_rd_s;
            validW     <= 1'b1;
        end else if (bubble_s) begin
            RegWriteW <= 1'b0;
            validW    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven single-cycle vectors
// through a scoreboard queue, plus hand sequences for load wait, hold,
// timeout, flush and mid-wait reset.
module tb_mem_wb_stage;

`ifdef LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid_m = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  funct3M = 3'd0;
    logic        RegWriteM = 1'b0;
    logic [4:0]  RdM = 5'd0;
    logic [31:0] ALUResultM = 32'd0, PCPlus4M = 32'd0, ImmExtM = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW, validW, stall_req, load_err;
    logic [4:0]  RdW;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .flush_i(flush_i), .stall_i(stall_i),
        .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RegWriteM(RegWriteM), .RdM(RdM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW),
        .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .RdW(RdW), .validW(validW),
        .stall_req(stall_req), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [1:0] src; logic [2:0] f3; logic rw; logic [4:0] rd;
        logic [31:0] alu, pc4, imm; logic rv; logic [31:0] rdata;
        logic e_v, e_rw; logic [4:0] e_rd; logic [1:0] e_src;
        logic [31:0] e_alu, e_rdata, e_pc4, e_imm;
    } vec_t;

    vec_t vecs[11];
    vec_t exp_q[$];
    vec_t e_v;
    int n_err = 0, n_checks = 0, stall_cnt = 0, err_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, ".validW"},     32'(validW),     32'(e.e_v));
        chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'(e.e_rw));
        chk({tag, ".RdW"},        32'(RdW),        32'(e.e_rd));
        chk({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(e.e_src));
        chk({tag, ".ALUResultW"}, ALUResultW,      e.e_alu);
        chk({tag, ".ReadDataW"},  ReadDataW,       e.e_rdata);
        chk({tag, ".PCPlus4W"},   PCPlus4W,        e.e_pc4);
        chk({tag, ".ImmExtW"},    ImmExtW,         e.e_imm);
    endtask

    task automatic drive_mem(input logic v, input logic [1:0] src, input logic [2:0] f3,
                             input logic rw, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        valid_m = v; ResultSrcM = src; funct3M = f3; RegWriteM = rw; RdM = rd;
        ALUResultM = alu; PCPlus4M = pc4; ImmExtM = imm;
    endtask

    // Load word that misses in the MEM cycle
    task automatic load_miss(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
        drive_mem(1'b1, 2'b01, 3'b010, 1'b1, rd, alu, pc4, 32'd0);
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ALUResultW"}, ALUResultW, 32'd0);
        chk({tag, ".ReadDataW"},  ReadDataW,  32'd0);
        chk({tag, ".PCPlus4W"},   PCPlus4W,   32'd0);
        chk({tag, ".ImmExtW"},    ImmExtW,    32'd0);
        chk({tag, ".ctrl"}, 32'({ResultSrcW, RegWriteW, RdW, validW, load_err}), 32'd0);
        chk({tag, ".stall_req"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        //          v    src    f3    rw   rd     alu         pc4        imm           rv    rdata          e_v  e_rw e_rd   e_src  e_alu       e_rdata                                  e_pc4      e_imm
        vecs[0]  = '{1'b1, 2'b00, 3'd0, 1'b1, 5'd5,  32'h10,   32'h104, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'd5,  2'b00, 32'h10,   32'h0,                                   32'h104, 32'h0};
        vecs[1]  = '{1'b1, 2'b01, 3'd0, 1'b1, 5'd6,  32'h1003, 32'h108, 32'h0,        1'b1, 32'h80FFFF12, 1'b1, 1'b1, 5'd6,  2'b01, 32'h1003, EXT ? 32'hFFFFFF80 : 32'h80FFFF12,     32'h108, 32'h0};
        vecs[2]  = '{1'b1, 2'b01, 3'd4, 1'b1, 5'd6,  32'h1003, 32'h10C, 32'h0,        1'b1, 32'h80FFFF12, 1'b1, 1'b1, 5'd6,  2'b01, 32'h1003, EXT ? 32'h00000080 : 32'h80FFFF12,     32'h10C, 32'h0};
        vecs[3]  = '{1'b1, 2'b01, 3'd1, 1'b1, 5'd8,  32'h2002, 32'h110, 32'h0,        1'b1, 32'h80017FFF, 1'b1, 1'b1, 5'd8,  2'b01, 32'h2002, EXT ? 32'hFFFF8001 : 32'h80017FFF,     32'h110, 32'h0};
        vecs[4]  = '{1'b1, 2'b01, 3'd5, 1'b1, 5'd8,  32'h2000, 32'h114, 32'h0,        1'b1, 32'h1234F00D, 1'b1, 1'b1, 5'd8,  2'b01, 32'h2000, EXT ? 32'h0000F00D : 32'h1234F00D,     32'h114, 32'h0};
        vecs[5]  = '{1'b1, 2'b01, 3'd2, 1'b1, 5'd9,  32'h3000, 32'h118, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 5'd9,  2'b01, 32'h3000, 32'hDEADBEEF,                            32'h118, 32'h0};
        vecs[6]  = '{1'b1, 2'b00, 3'd0, 1'b1, 5'd0,  32'h77,   32'h11C, 32'h5,        1'b0, 32'h0,        1'b1, 1'b0, 5'd0,  2'b00, 32'h77,   32'h0,                                   32'h11C, 32'h5};
        vecs[7]  = '{1'b0, 2'b11, 3'd0, 1'b1, 5'd3,  32'h999,  32'h999, 32'h999,      1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  2'b00, 32'h77,   32'h0,                                   32'h11C, 32'h5};
        vecs[8]  = '{1'b1, 2'b10, 3'd0, 1'b1, 5'd31, 32'h20,   32'h44,  32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'd31, 2'b10, 32'h20,   32'h0,                                   32'h44,  32'h0};
        vecs[9]  = '{1'b1, 2'b11, 3'd0, 1'b1, 5'd2,  32'h24,   32'h48,  32'hABCDE000, 1'b0, 32'h0,        1'b1, 1'b1, 5'd2,  2'b11, 32'h24,   32'h0,                                   32'h48,  32'hABCDE000};
        vecs[10] = '{1'b1, 2'b01, 3'd0, 1'b1, 5'd4,  32'h1,    32'h4C,  32'h0,        1'b1, 32'h00007F00, 1'b1, 1'b1, 5'd4,  2'b01, 32'h1,    EXT ? 32'h0000007F : 32'h00007F00,     32'h4C,  32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single-cycle captures through the scoreboard
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_mem(vecs[i].v, vecs[i].src, vecs[i].f3, vecs[i].rw, vecs[i].rd,
                      vecs[i].alu, vecs[i].pc4, vecs[i].imm);
            mem_rvalid = vecs[i].rv;
            mem_rdata  = vecs[i].rdata;
            exp_q.push_back(vecs[i]);
            #1 chk($sformatf("vec%0d.stall_req", i), 32'(stall_req), 32'd0);
            @(posedge clk); #1;
            e_v = exp_q.pop_front();
            check_all($sformatf("vec%0d", i), e_v);
        end

        // stall_i in IDLE: W registers hold, MEM inputs not sampled
        @(negedge clk);
        drive_mem(1'b1, 2'b00, 3'd0, 1'b1, 5'd13, 32'h55, 32'h150, 32'h0);
        mem_rvalid = 1'b0; mem_rdata = 32'd0; stall_i = 1'b1;
        @(posedge clk); #1;
        chk("idle_stall.ALUResultW", ALUResultW, 32'h1);
        chk("idle_stall.RdW", 32'(RdW), 32'd4);
        @(negedge clk) stall_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_release.ALUResultW", ALUResultW, 32'h55);
        chk("idle_release.RdW", 32'(RdW), 32'd13);

        // LW answered on the third stalled cycle; metadata must come from the latch
        @(negedge clk) load_miss(5'd7, 32'h40, 32'h200);
        #1 if (stall_req) stall_cnt++;
        @(posedge clk); #1;
        chk("lw_wait.validW", 32'(validW), 32'd0);
        chk("lw_wait.RegWriteW", 32'(RegWriteW), 32'd0);
        @(negedge clk) begin ALUResultM = 32'hBAD0; RdM = 5'd30; end
        #1 if (stall_req) stall_cnt++;
        @(negedge clk) begin mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; end
        #1 if (stall_req) stall_cnt++;
        @(posedge clk); #1;
        e_v = '{1'b0, 2'b00, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 5'd7, 2'b01, 32'h40, 32'hCAFEF00D, 32'h200, 32'h0};
        check_all("lw_late", e_v);
        @(negedge clk) begin valid_m = 1'b0; mem_rvalid = 1'b0; end
        #1 chk("lw_late.stall_req_drop", 32'(stall_req), 32'd0);
        chk("lw_late.stall_cycles", 32'(stall_cnt), 32'd3);

        // Data arrives while stall_i is high: HOLD, then release
        @(negedge clk) load_miss(5'd9, 32'h50, 32'h300);
        @(posedge clk);
        @(negedge clk) begin stall_i = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; end
        @(posedge clk); #1;
        chk("hold.validW", 32'(validW), 32'd0);
        @(negedge clk) begin mem_rvalid = 1'b0; mem_rdata = 32'hFFFFFFFF; end
        #1 chk("hold.stall_req", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        chk("hold.frozen_validW", 32'(validW), 32'd0);
        chk("hold.frozen_ReadDataW", ReadDataW, 32'hCAFEF00D);
        @(negedge clk) stall_i = 1'b0;
        #1 chk("hold.stall_req_release", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        chk("hold_out.validW", 32'(validW), 32'd1);
        chk("hold_out.ReadDataW", ReadDataW, 32'h11223344);
        chk("hold_out.RdW", 32'(RdW), 32'd9);
        @(negedge clk) valid_m = 1'b0;
        #1 chk("hold_out.stall_req", 32'(stall_req), 32'd0);

        // Unanswered load: timeout after 15 wait cycles
        @(negedge clk) load_miss(5'd10, 32'h60, 32'h400);
        err_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (load_err) begin
                err_edge = e;
                break;
            end
        end
        chk("timeout.edge", 32'(err_edge), 32'd16);
        chk("timeout.validW", 32'(validW), 32'd0);
        chk("timeout.RegWriteW", 32'(RegWriteW), 32'd0);
        @(negedge clk) valid_m = 1'b0;
        #1 chk("timeout.stall_req", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        chk("timeout.pulse_width", 32'(load_err), 32'd0);

        // Flush during WAIT; late rvalid must be ignored
        @(negedge clk) load_miss(5'd11, 32'h70, 32'h500);
        @(posedge clk);
        @(negedge clk) flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush.validW", 32'(validW), 32'd0);
        @(negedge clk) begin flush_i = 1'b0; valid_m = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; end
        #1 chk("flush.stall_req", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        chk("flush_late.validW", 32'(validW), 32'd0);
        chk("flush_late.RegWriteW", 32'(RegWriteW), 32'd0);
        chk("flush_late.ReadDataW", ReadDataW, 32'h11223344);
        @(negedge clk) mem_rvalid = 1'b0;

        // Reset in the middle of WAIT
        @(negedge clk) load_miss(5'd12, 32'h80, 32'h600);
        @(posedge clk);
        @(negedge clk) begin rst_n = 1'b0; valid_m = 1'b0; end
        #1 chk_zero("mid_reset");
        @(negedge clk) begin
            rst_n = 1'b1;
            drive_mem(1'b1, 2'b00, 3'd0, 1'b1, 5'd5, 32'h99, 32'h700, 32'h0);
        end
        @(posedge clk); #1;
        chk("post_reset.validW", 32'(validW), 32'd1);
        chk("post_reset.ALUResultW", ALUResultW, 32'h99);
        chk("post_reset.RegWriteW", 32'(RegWriteW), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
